// File: rtl/id_stage_pkg.sv
// Shared definitions for the SIMD instruction-decode stage: sizes, instruction
// field positions, the nop opcode mask and the instruction-format decode.
package id_stage_pkg;

  localparam int DATA_W   = 128;
  localparam int NUM_REGS = 32;
  localparam int INSTR_W  = 25;

  // Register address field width inside the instruction word
  localparam int REG_AW = 5;

  // Format selector bits
  localparam int FMT_HI = 24;
  localparam int FMT_LO = 23;

  // Register fields (R3 / R4; load-immediate reuses rd)
  localparam int RD_LSB  = 0;
  localparam int RS1_LSB = 5;
  localparam int RS2_LSB = 10;
  localparam int RS3_LSB = 15;

  // R3 opcode field
  localparam int OPC_LSB = 15;
  localparam int OPC_W   = 8;

  // Load-immediate fields
  localparam int IMM_LSB = 5;
  localparam int IMM_W   = 16;
  localparam int IDX_LSB = 21;
  localparam int IDX_W   = 3;

  // An R3 instruction whose opcode bits under this mask are all zero is a nop
  localparam logic [OPC_W-1:0] NOP_MASK = 8'h0F;

  typedef enum logic [1:0] {
    FMT_LI = 2'd0,
    FMT_R4 = 2'd1,
    FMT_R3 = 2'd2
  } fmt_e;

  // Classify an instruction from its two top bits
  function automatic fmt_e decode_fmt(input logic [1:0] top);
    if (!top[1]) return FMT_LI;
    if (!top[0]) return FMT_R4;
    return FMT_R3;
  endfunction

  // Every format writes rd except the R3 nop
  function automatic logic writes_rd(input fmt_e fmt, input logic [OPC_W-1:0] opc);
    return !((fmt == FMT_R3) && ((opc & NOP_MASK) == '0));
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundle of decode-stage traffic: fetch/writeback inputs and the registered
// execute-side outputs. The bench/upstream side uses master, id_stage slave.
interface id_stage_if #(
  parameter int DATA_W  = id_stage_pkg::DATA_W,
  parameter int INSTR_W = id_stage_pkg::INSTR_W
);

  logic               instr_valid;
  logic [INSTR_W-1:0] instructionIF;
  logic               wb_valid;
  logic [INSTR_W-1:0] instructionWB;
  logic [DATA_W-1:0]  ALUOut;

  logic [DATA_W-1:0]  rs1;
  logic [DATA_W-1:0]  rs2;
  logic [DATA_W-1:0]  rs3;
  logic [INSTR_W-1:0] instructionID;
  logic               id_valid;
  logic               fowarded_data;

  modport master (
    output instr_valid, instructionIF, wb_valid, instructionWB, ALUOut,
    input  rs1, rs2, rs3, instructionID, id_valid, fowarded_data
  );

  modport slave (
    input  instr_valid, instructionIF, wb_valid, instructionWB, ALUOut,
    output rs1, rs2, rs3, instructionID, id_valid, fowarded_data
  );

endinterface

// File: rtl/id_stage_regfile.sv
// SIMD register file: three combinational read ports, one write port, and a
// write-before-read bypass so a reader sees a same-cycle writeback value.
module simd_regfile #(
  parameter int DATA_W   = id_stage_pkg::DATA_W,
  parameter int NUM_REGS = id_stage_pkg::NUM_REGS,
  parameter int AW       = id_stage_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  input  logic [AW-1:0]     raddr3,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] rdata3,
  output logic              hit1,
  output logic              hit2,
  output logic              hit3
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  // Storage: reset clears every entry (and so discards a writeback held during reset)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports: a matching same-cycle write overrides the stored value
  always_comb begin
    hit1   = we && (raddr1 == waddr);
    hit2   = we && (raddr2 == waddr);
    hit3   = we && (raddr3 == waddr);
    rdata1 = hit1 ? wdata : mem[raddr1];
    rdata2 = hit2 ? wdata : mem[raddr2];
    rdata3 = hit3 ? wdata : mem[raddr3];
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: decodes read addresses from the fetched
// instruction, reads the SIMD register file (with writeback bypass) and
// registers operands, instruction and valid for execute.
module id_stage #(
  parameter int DATA_W   = id_stage_pkg::DATA_W,
  parameter int NUM_REGS = id_stage_pkg::NUM_REGS,
  parameter int INSTR_W  = id_stage_pkg::INSTR_W
) (
  input logic       clk,
  input logic       rst_n,
  id_stage_if.slave bus
);

  import id_stage_pkg::*;

  fmt_e               fmt_id;
  fmt_e               fmt_wb;
  logic [REG_AW-1:0]  ra1, ra2, ra3;
  logic [REG_AW-1:0]  wb_rd;
  logic               wb_we;
  logic [DATA_W-1:0]  rd1, rd2, rd3;
  logic               hit1, hit2, hit3;

  logic [DATA_W-1:0]  rs1_p1, rs2_p1, rs3_p1;
  logic [INSTR_W-1:0] instr_p1;
  logic               vld_p1;
  logic               fwd_p1;

  // ---- stage p0: decode and register-file read ----

  // Read-address selection per instruction format; unused ports read register 0
  always_comb begin
    fmt_id = decode_fmt(bus.instructionIF[FMT_HI:FMT_LO]);
    ra1    = '0;
    ra2    = '0;
    ra3    = '0;
    case (fmt_id)
      FMT_LI: begin
        ra1 = bus.instructionIF[RD_LSB +: REG_AW];
      end
      FMT_R4: begin
        ra1 = bus.instructionIF[RS1_LSB +: REG_AW];
        ra2 = bus.instructionIF[RS2_LSB +: REG_AW];
        ra3 = bus.instructionIF[RS3_LSB +: REG_AW];
      end
      default: begin
        ra1 = bus.instructionIF[RS1_LSB +: REG_AW];
        ra2 = bus.instructionIF[RS2_LSB +: REG_AW];
      end
    endcase
  end

  // Writeback enable: valid and not an R3 nop
  always_comb begin
    fmt_wb = decode_fmt(bus.instructionWB[FMT_HI:FMT_LO]);
    wb_rd  = bus.instructionWB[RD_LSB +: REG_AW];
    wb_we  = bus.wb_valid && writes_rd(fmt_wb, bus.instructionWB[OPC_LSB +: OPC_W]);
  end

  simd_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .AW       (REG_AW)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (bus.ALUOut),
    .raddr1 (ra1),
    .raddr2 (ra2),
    .raddr3 (ra3),
    .rdata1 (rd1),
    .rdata2 (rd2),
    .rdata3 (rd3),
    .hit1   (hit1),
    .hit2   (hit2),
    .hit3   (hit3)
  );

  // ---- stage p1: execute-side pipeline registers ----

  // Load every cycle; an empty slot clears instruction/flags but keeps operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_p1   <= '0;
      rs2_p1   <= '0;
      rs3_p1   <= '0;
      instr_p1 <= '0;
      vld_p1   <= 1'b0;
      fwd_p1   <= 1'b0;
    end else begin
      vld_p1 <= bus.instr_valid;
      if (bus.instr_valid) begin
        rs1_p1   <= rd1;
        rs2_p1   <= rd2;
        rs3_p1   <= rd3;
        instr_p1 <= bus.instructionIF;
        fwd_p1   <= hit1 | hit2 | hit3;
      end else begin
        instr_p1 <= '0;
        fwd_p1   <= 1'b0;
      end
    end
  end

  assign bus.rs1           = rs1_p1;
  assign bus.rs2           = rs2_p1;
  assign bus.rs3           = rs3_p1;
  assign bus.instructionID = instr_p1;
  assign bus.id_valid      = vld_p1;
  assign bus.fowarded_data = fwd_p1;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by random traffic, all
// compared against a behavioural register-file model kept here.
module tb_id_stage;

  localparam int DW = 128;
  localparam int NR = 32;
  localparam int IW = 25;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  id_stage_if #(.DATA_W(DW), .INSTR_W(IW)) ifc ();

  id_stage #(.DATA_W(DW), .NUM_REGS(NR), .INSTR_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [DW-1:0] ref_rf [NR];
  logic [DW-1:0] e_rs1, e_rs2, e_rs3;
  logic [IW-1:0] e_instr;
  logic          e_vld, e_fwd;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk_r3(input logic [7:0] opc, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [4:0] d);
    return {2'b11, opc, s2, s1, d};
  endfunction

  function automatic logic [IW-1:0] mk_r4(input logic [4:0] s3, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [4:0] d);
    return {2'b10, 3'b000, s3, s2, s1, d};
  endfunction

  function automatic logic [IW-1:0] mk_li(input logic [2:0] idx, input logic [15:0] imm,
                                          input logic [4:0] d);
    return {1'b0, idx, imm, d};
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < NR; i++) ref_rf[i] = '0;
    e_rs1 = '0; e_rs2 = '0; e_rs3 = '0;
    e_instr = '0; e_vld = 1'b0; e_fwd = 1'b0;
  endtask

  // Expected result of one clock edge, then the architectural register update
  task automatic ref_step(input logic iv, input logic [IW-1:0] ii, input logic wv,
                          input logic [IW-1:0] iw, input logic [DW-1:0] alu);
    logic       wr;
    int         wrd;
    int         a [3];
    logic [DW-1:0] v [3];
    logic       any;
    wr  = wv && !(iw[24:23] == 2'b11 && iw[18:15] == 4'h0);
    wrd = int'(iw[4:0]);
    if (iv) begin
      if (ii[24] == 1'b0) begin
        a[0] = int'(ii[4:0]); a[1] = 0; a[2] = 0;
      end else if (ii[23] == 1'b0) begin
        a[0] = int'(ii[9:5]); a[1] = int'(ii[14:10]); a[2] = int'(ii[19:15]);
      end else begin
        a[0] = int'(ii[9:5]); a[1] = int'(ii[14:10]); a[2] = 0;
      end
      any = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (wr && a[k] == wrd) begin
          v[k] = alu;
          any  = 1'b1;
        end else begin
          v[k] = ref_rf[a[k]];
        end
      end
      e_rs1 = v[0]; e_rs2 = v[1]; e_rs3 = v[2];
      e_instr = ii; e_vld = 1'b1; e_fwd = any;
    end else begin
      e_instr = '0; e_vld = 1'b0; e_fwd = 1'b0;
    end
    if (wr) ref_rf[wrd] = alu;
  endtask

  task automatic check_outs();
    check_eq("rs1", ifc.rs1, e_rs1);
    check_eq("rs2", ifc.rs2, e_rs2);
    check_eq("rs3", ifc.rs3, e_rs3);
    check_eq("instructionID", ifc.instructionID, e_instr);
    check_eq("id_valid", ifc.id_valid, e_vld);
    check_eq("fowarded_data", ifc.fowarded_data, e_fwd);
  endtask

  // Drive inputs now, advance one rising edge, compare against the model
  task automatic drive_check(input logic iv, input logic [IW-1:0] ii, input logic wv,
                             input logic [IW-1:0] iw, input logic [DW-1:0] alu);
    ifc.instr_valid   = iv;
    ifc.instructionIF = ii;
    ifc.wb_valid      = wv;
    ifc.instructionWB = iw;
    ifc.ALUOut        = alu;
    ref_step(iv, ii, wv, iw, alu);
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic cycle(input logic iv, input logic [IW-1:0] ii, input logic wv,
                       input logic [IW-1:0] iw, input logic [DW-1:0] alu);
    @(negedge clk);
    drive_check(iv, ii, wv, iw, alu);
  endtask

  task automatic idle_inputs();
    ifc.instr_valid   = 1'b0;
    ifc.instructionIF = '0;
    ifc.wb_valid      = 1'b0;
    ifc.instructionWB = '0;
    ifc.ALUOut        = '0;
  endtask

  function automatic logic [IW-1:0] rand_instr();
    logic [4:0] d, s1, s2, s3;
    logic [7:0] opc;
    d  = 5'($urandom_range(0, 7));
    s1 = 5'($urandom_range(0, 7));
    s2 = 5'($urandom_range(0, 7));
    s3 = 5'($urandom_range(0, 7));
    opc = ($urandom_range(0, 3) == 0) ? {4'($urandom), 4'h0} : 8'($urandom);
    case ($urandom_range(0, 2))
      0:       return mk_li(3'($urandom), 16'($urandom), d);
      1:       return mk_r4(s3, s2, s1, d);
      default: return mk_r3(opc, s2, s1, d);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    ref_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;

    // Reads of a cleared file
    cycle(1'b1, mk_r3(8'h01, 5'd2, 5'd1, 5'd0), 1'b0, '0, '0);
    check_eq("t028_rs1", ifc.rs1, '0);
    check_eq("t028_vld", ifc.id_valid, 1'b1);
    check_eq("t028_fwd", ifc.fowarded_data, 1'b0);

    // Write then read next cycle: stored value, no bypass
    cycle(1'b0, '0, 1'b1, mk_r3(8'h01, 5'd0, 5'd0, 5'd5), 128'h1234);
    cycle(1'b1, mk_r3(8'h02, 5'd0, 5'd5, 5'd1), 1'b0, '0, '0);
    check_eq("t029_rs1", ifc.rs1, 128'h1234);
    check_eq("t029_fwd", ifc.fowarded_data, 1'b0);

    // Same-cycle write and R4 read of the same register
    cycle(1'b1, mk_r4(5'd7, 5'd1, 5'd2, 5'd3), 1'b1, mk_r4(5'd0, 5'd0, 5'd0, 5'd7), 128'hFFFF);
    check_eq("t030_rs3", ifc.rs3, 128'hFFFF);
    check_eq("t030_fwd", ifc.fowarded_data, 1'b1);
    cycle(1'b1, mk_li(3'd0, 16'h0, 5'd7), 1'b0, '0, '0);
    check_eq("t030_reg7", ifc.rs1, 128'hFFFF);

    // Nop in writeback must not write
    cycle(1'b0, '0, 1'b1, mk_r3(8'h00, 5'd0, 5'd0, 5'd3), 128'hAAAA);
    cycle(1'b1, mk_li(3'd0, 16'h0, 5'd3), 1'b0, '0, '0);
    check_eq("t031_reg3", ifc.rs1, '0);

    // Load-immediate reads rd and passes the instruction through
    cycle(1'b0, '0, 1'b1, mk_li(3'd2, 16'hBEEF, 5'd9), 128'h5);
    cycle(1'b1, mk_li(3'd5, 16'hC0DE, 5'd9), 1'b0, '0, '0);
    check_eq("t032_rs1", ifc.rs1, 128'h5);
    check_eq("t032_instr", ifc.instructionID, mk_li(3'd5, 16'hC0DE, 5'd9));

    // Idle slot: operands hold, valid and instruction drop
    cycle(1'b0, mk_r4(5'd7, 5'd7, 5'd7, 5'd7), 1'b0, '0, '0);
    check_eq("idle_rs1", ifc.rs1, 128'h5);

    // Register 0 is writable
    cycle(1'b0, '0, 1'b1, mk_r3(8'h11, 5'd0, 5'd0, 5'd0), 128'h42);
    cycle(1'b1, mk_r3(8'h01, 5'd0, 5'd0, 5'd1), 1'b0, '0, '0);
    check_eq("reg0_rs1", ifc.rs1, 128'h42);

    // Reset mid-stream
    cycle(1'b1, mk_r4(5'd7, 5'd4, 5'd9, 5'd1), 1'b1, mk_r3(8'h01, 5'd0, 5'd0, 5'd4), 128'h77);
    @(negedge clk);
    #2;
    ifc.wb_valid      = 1'b1;
    ifc.instructionWB = mk_r3(8'h01, 5'd0, 5'd0, 5'd6);
    ifc.ALUOut        = 128'hDEAD;
    ifc.instr_valid   = 1'b1;
    ifc.instructionIF = mk_r4(5'd6, 5'd6, 5'd6, 5'd6);
    rst_n = 1'b0;
    #1;
    check_eq("t033_rs1", ifc.rs1, '0);
    check_eq("t033_rs3", ifc.rs3, '0);
    check_eq("t033_instr", ifc.instructionID, '0);
    check_eq("t033_vld", ifc.id_valid, 1'b0);
    check_eq("t033_fwd", ifc.fowarded_data, 1'b0);
    ref_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_check(1'b1, mk_li(3'd0, 16'h0, 5'd4), 1'b0, '0, '0);
    check_eq("t033_reg4", ifc.rs1, '0);
    cycle(1'b1, mk_li(3'd0, 16'h0, 5'd6), 1'b0, '0, '0);
    check_eq("t033_reg6", ifc.rs1, '0);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      cycle(($urandom_range(0, 9) < 8), rand_instr(),
            ($urandom_range(0, 9) < 7), rand_instr(),
            {$urandom, $urandom, $urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
